// File: rtl/dac_i2s_tx.sv
// -----------------------------------------------------------------------------
// dac_i2s_tx
//
// Audio output stage between the APU mixer and the external serial DAC pins.
// The per-clock APU sample is averaged over one 256-clock LR frame (a 256:1
// boxcar decimator). The average is converted from offset-binary to two's
// complement and shifted out MSB-first, left-justified, on both channels.
// SYSCK, BCK and LRCLK all come from one free-running 8-bit divider, so every
// pin is phase-locked to the frame without extra synchronisation.
//
// Ports:
//   clk_i         system clock, all logic on the rising edge
//   rst_i         synchronous active-high reset
//   audio_i       unsigned APU mix sample, taken every clock
//   mute_i        mute request, applied only at frame boundaries
//   sysck_o       DAC system clock  (divider bit 0, clk/2)
//   bck_o         DAC bit clock     (divider bit 1, clk/4)
//   lrclk_o       word select       (divider bit 7, 0 = left, 1 = right)
//   data_o        registered serial data
//   mute_o        frame-aligned mute to the DAC pin
//   sample_o      current averaged sample, offset-binary (monitor use)
//   sample_stb_o  one-cycle pulse in the first cycle sample_o holds a new value
// -----------------------------------------------------------------------------
module dac_i2s_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int INVERT_MSB = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] audio_i,
  input  logic                mute_i,
  output logic                sysck_o,
  output logic                bck_o,
  output logic                lrclk_o,
  output logic                data_o,
  output logic                mute_o,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_stb_o
);

  // Eight extra accumulator bits hold the sum of 256 full-scale samples
  // without overflow; dropping them again divides by 256.
  localparam int ACC_W = SAMPLE_W + 8;

  localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MSB_FLIP = (INVERT_MSB != 0) ? MIDSCALE : '0;

  // Divider / frame position
  logic [7:0]          cnt_q, cnt_d;
  // Boxcar accumulator and its result
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SAMPLE_W-1:0] sampleBuf_q, sampleBuf_d;
  // Word being serialised during the current frame
  logic [SAMPLE_W-1:0] word_q, word_d;
  // Output registers
  logic                data_q, data_d;
  logic                stb_q, stb_d;
  logic                mute_q, mute_d;

  // Helper nets
  logic                frameEnd;
  logic [ACC_W-1:0]    accSum;
  logic [SAMPLE_W-1:0] frameAvg;
  logic [4:0]          slot;

  // The last clock of the frame is where the average closes, the next word
  // is latched and the mute request is sampled, all in the same edge.
  assign frameEnd = (cnt_q == 8'hFF);

  // The sample presented in the closing cycle still belongs to this frame,
  // so the average is taken from acc + audio_i rather than from acc alone.
  assign accSum   = acc_q + ACC_W'(audio_i);
  assign frameAvg = accSum[ACC_W-1:8];

  // Each channel half is 128 clocks = 32 BCK periods; bits [6:2] of the
  // divider give the BCK slot inside the current channel.
  assign slot = cnt_q[6:2];

  // ---------------------------------------------------------------------------
  // Divider: free-running, wraps naturally from FF to 00.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q + 8'd1;
  end

  // ---------------------------------------------------------------------------
  // Accumulator, frame buffer, frame word and mute sampling.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d       = accSum;
    sampleBuf_d = sampleBuf_q;
    word_d      = word_q;
    mute_d      = mute_q;
    if (frameEnd) begin
      acc_d       = '0;
      sampleBuf_d = frameAvg;
      word_d      = frameAvg ^ MSB_FLIP;
      mute_d      = mute_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Serial data: slots 0..15 carry the word MSB first, slots 16..31 are zero.
  // ~slot[3:0] equals 15 - slot for the active slots. Because data_o is
  // registered, the bit chosen in slot N appears one clock after the slot
  // starts, i.e. while cnt[1:0] = 01, and holds through the BCK rising edge.
  // Slot 31 always yields zero, so a word or mute change at the frame edge
  // can never corrupt a bit already on the pin.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d = 1'b0;
    if (!mute_q && !slot[4]) begin
      data_d = word_q[~slot[3:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe: high in the cycle right after the frame closes, which is the
  // first cycle sampleBuf_q holds the new average.
  // ---------------------------------------------------------------------------
  always_comb begin
    stb_d = frameEnd;
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset parks the output at silence: midscale sample,
  // zero word, muted, and the divider at the start of a left channel.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= 8'h00;
      acc_q       <= '0;
      sampleBuf_q <= MIDSCALE;
      word_q      <= '0;
      data_q      <= 1'b0;
      stb_q       <= 1'b0;
      mute_q      <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sampleBuf_q <= sampleBuf_d;
      word_q      <= word_d;
      data_q      <= data_d;
      stb_q       <= stb_d;
      mute_q      <= mute_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pin drivers: clocks straight from the divider, everything else from
  // registers so the DAC pins are glitch-free.
  // ---------------------------------------------------------------------------
  assign sysck_o      = cnt_q[0];
  assign bck_o        = cnt_q[1];
  assign lrclk_o      = cnt_q[7];
  assign data_o       = data_q;
  assign mute_o       = mute_q;
  assign sample_o     = sampleBuf_q;
  assign sample_stb_o = stb_q;

endmodule

// File: tb/tb_dac_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_dac_i2s_tx
//
// Directed plus randomised stimulus for dac_i2s_tx. A frame-level reference
// model (sample queue averaged with a division, and a precomputed 256-entry
// expected bit stream per frame) is compared against the pins every cycle,
// alongside a free-running clock period / data-stability checker.
// -----------------------------------------------------------------------------
module tb_dac_i2s_tx;

  logic        clk_i   = 1'b0;
  logic        rst_i   = 1'b1;
  logic [15:0] audio_i = 16'h0000;
  logic        mute_i  = 1'b0;
  logic        sysck_o;
  logic        bck_o;
  logic        lrclk_o;
  logic        data_o;
  logic        mute_o;
  logic [15:0] sample_o;
  logic        sample_stb_o;

  dac_i2s_tx #(
    .SAMPLE_W   (16),
    .INVERT_MSB (1)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .audio_i      (audio_i),
    .mute_i       (mute_i),
    .sysck_o      (sysck_o),
    .bck_o        (bck_o),
    .lrclk_o      (lrclk_o),
    .data_o       (data_o),
    .mute_o       (mute_o),
    .sample_o     (sample_o),
    .sample_stb_o (sample_stb_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model state. pos is the frame position the next clock edge
  // will see (0..255), counted from reset release.
  int          pos = 0;
  logic [15:0] frameSamples[$];
  bit          expBits[$];
  logic [15:0] expBuf  = 16'h8000;
  logic [15:0] expWord = 16'h0000;
  logic        expMute = 1'b1;
  logic        expStb  = 1'b0;
  logic        expData = 1'b0;

  // Free-running checker state
  int   cycle       = 0;
  int   lastSysRise = -1;
  int   lastBckRise = -1;
  int   lastLrRise  = -1;
  logic prevSys     = 1'b0;
  logic prevBck     = 1'b0;
  logic prevLr      = 1'b0;
  logic prevData    = 1'b0;

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  // Expected data_o stream for one frame, one entry per clock starting at the
  // clock where the divider reads 01: each channel carries the 16 word bits
  // for 4 clocks each, then 64 zero clocks. Muted frames are all zero.
  task automatic loadFrameBits();
    expBits.delete();
    for (int ch = 0; ch < 2; ch++) begin
      for (int b = 15; b >= 0; b--) begin
        repeat (4) expBits.push_back(expMute ? 1'b0 : expWord[b]);
      end
      repeat (64) expBits.push_back(1'b0);
    end
  endtask

  // Advance the reference model by one clock edge with the given inputs.
  task automatic modelEdge(input logic [15:0] a, input logic m, input logic r);
    longint sum;
    if (r) begin
      pos     = 0;
      frameSamples.delete();
      expBuf  = 16'h8000;
      expWord = 16'h0000;
      expMute = 1'b1;
      expStb  = 1'b0;
      expData = 1'b0;
      expBits.delete();
      repeat (256) expBits.push_back(1'b0);
      lastSysRise = -1;
      lastBckRise = -1;
      lastLrRise  = -1;
    end else begin
      expStb = (pos == 255);
      frameSamples.push_back(a);
      expData = expBits.pop_front();
      if (pos == 255) begin
        sum = 0;
        foreach (frameSamples[k]) sum += longint'(frameSamples[k]);
        expBuf  = 16'(sum / 256);
        expWord = expBuf ^ 16'h8000;
        expMute = m;
        loadFrameBits();
        frameSamples.delete();
      end
      pos = (pos + 1) % 256;
    end
  endtask

  // Per-cycle comparison of all pins against the model, plus clock periods
  // and the rule that data_o only moves while BCK is low and not rising.
  task automatic checkCycle(input logic wasReset);
    cycle++;
    checkOutput("data_o", data_o, expData);
    checkOutput("mute_o", mute_o, expMute);
    checkOutput("sample_o", sample_o, expBuf);
    checkOutput("sample_stb_o", sample_stb_o, expStb);
    checkOutput("lrclk_o", lrclk_o, (pos >= 128));
    if (sysck_o && !prevSys) begin
      if (lastSysRise >= 0) checkOutput("sysck_period", cycle - lastSysRise, 2);
      lastSysRise = cycle;
    end
    if (bck_o && !prevBck) begin
      if (lastBckRise >= 0) checkOutput("bck_period", cycle - lastBckRise, 4);
      lastBckRise = cycle;
    end
    if (lrclk_o && !prevLr) begin
      if (lastLrRise >= 0) checkOutput("lrclk_period", cycle - lastLrRise, 256);
      lastLrRise = cycle;
    end
    if (!wasReset && (data_o !== prevData)) begin
      checkOutput("data_vs_bck", {bck_o, prevBck}, 2'b00);
    end
    prevSys  = sysck_o;
    prevBck  = bck_o;
    prevLr   = lrclk_o;
    prevData = data_o;
  endtask

  // Drive one clock of inputs, step the model, and check on the falling edge.
  task automatic applyStimulus(input logic [15:0] a, input logic m, input logic r);
    audio_i = a;
    mute_i  = m;
    rst_i   = r;
    @(posedge clk_i);
    modelEdge(a, m, r);
    @(negedge clk_i);
    checkCycle(r);
  endtask

  // Run one whole frame (entered with pos == 0). Audio switches from a0 to
  // a1 halfway; mute_i switches from m0 to m1 at position muteAt. The data
  // bit seen right after each BCK rise is collected per channel section,
  // and mute_o is captured in the last cycle before the frame boundary.
  task automatic runFrameCollect(input logic [15:0] a0, input logic [15:0] a1,
                                 input logic m0, input logic m1, input int muteAt,
                                 output logic [15:0] lw, output logic [15:0] tail,
                                 output logic [15:0] rw, output logic muteLate);
    lw = '0; tail = '0; rw = '0; muteLate = 1'bx;
    for (int i = 0; i < 256; i++) begin
      applyStimulus((i < 128) ? a0 : a1, (i < muteAt) ? m0 : m1, 1'b0);
      if (pos % 4 == 2) begin
        if (pos < 64)       lw   = {lw[14:0], data_o};
        else if (pos < 128) tail = {tail[14:0], data_o};
        else if (pos < 192) rw   = {rw[14:0], data_o};
      end
      if (pos == 255) muteLate = mute_o;
    end
  endtask

  initial begin
    logic [15:0] lw, tail, rw;
    logic        muteLate;
    logic        curMute;
    int          n;

    // Reset for three clocks and check every pin is at its idle value.
    repeat (3) applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("reset_sample", sample_o, 16'h8000);
    checkOutput("reset_mute", mute_o, 1'b1);
    checkOutput("reset_clocks", {sysck_o, bck_o, lrclk_o}, 3'b000);
    checkOutput("reset_data", data_o, 1'b0);
    checkOutput("reset_stb", sample_stb_o, 1'b0);

    // Constant 0x1234: first strobe on the 256th clock after reset release.
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(16'h1234, 1'b0, 1'b0);
      if (sample_stb_o === 1'b1) begin
        n = i;
        break;
      end
    end
    checkOutput("first_stb_clock", n, 256);
    checkOutput("avg_1234", sample_o, 16'h1234);

    // Frames 2 and 3 serialise 0x1234 ^ 0x8000 on both channels.
    runFrameCollect(16'h1234, 16'h1234, 1'b0, 1'b0, 256, lw, tail, rw, muteLate);
    checkOutput("word_9234_left", lw, 16'h9234);
    checkOutput("word_9234_tail", tail, 16'h0000);
    checkOutput("word_9234_right", rw, 16'h9234);
    checkOutput("mute_released", mute_o, 1'b0);
    runFrameCollect(16'h1234, 16'h1234, 1'b0, 1'b0, 256, lw, tail, rw, muteLate);
    checkOutput("word_9234_frame3", lw, 16'h9234);

    // Full scale then zero: no wrap in the accumulator.
    runFrameCollect(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 256, lw, tail, rw, muteLate);
    checkOutput("avg_ffff", sample_o, 16'hFFFF);
    runFrameCollect(16'h0000, 16'h0000, 1'b0, 1'b0, 256, lw, tail, rw, muteLate);
    checkOutput("word_7fff", lw, 16'h7FFF);
    checkOutput("avg_0000", sample_o, 16'h0000);

    // Half a frame of zero, half of 0x0100 averages to 0x0080.
    runFrameCollect(16'h0000, 16'h0100, 1'b0, 1'b0, 256, lw, tail, rw, muteLate);
    checkOutput("word_8000", lw, 16'h8000);
    checkOutput("avg_half", sample_o, 16'h0080);

    // Mute asserted at position 0x40: the current frame finishes unmuted.
    runFrameCollect(16'h1234, 16'h1234, 1'b0, 1'b1, 8'h40, lw, tail, rw, muteLate);
    checkOutput("word_8080_unmuted", lw, 16'h8080);
    checkOutput("mute_late_still_0", muteLate, 1'b0);
    checkOutput("mute_rises_at_frame", mute_o, 1'b1);

    // Mute released mid-frame: stays muted until the next boundary.
    runFrameCollect(16'h1234, 16'h1234, 1'b1, 1'b0, 8'h40, lw, tail, rw, muteLate);
    checkOutput("muted_left_zero", lw, 16'h0000);
    checkOutput("muted_right_zero", rw, 16'h0000);
    checkOutput("mute_late_still_1", muteLate, 1'b1);
    checkOutput("mute_falls_at_frame", mute_o, 1'b0);
    runFrameCollect(16'h1234, 16'h1234, 1'b0, 1'b0, 256, lw, tail, rw, muteLate);
    checkOutput("word_resumed", lw, 16'h9234);

    // One-clock reset at position 0x9A during a random stream.
    while (pos != 8'h9A) applyStimulus(16'($urandom), 1'b0, 1'b0);
    applyStimulus(16'($urandom), 1'b0, 1'b1);
    checkOutput("midreset_sample", sample_o, 16'h8000);
    checkOutput("midreset_mute", mute_o, 1'b1);
    checkOutput("midreset_clocks", {sysck_o, bck_o, lrclk_o}, 3'b000);
    checkOutput("midreset_data", data_o, 1'b0);
    checkOutput("midreset_stb", sample_stb_o, 1'b0);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(16'($urandom), 1'b0, 1'b0);
      if (sample_stb_o === 1'b1) begin
        n = i;
        break;
      end
    end
    checkOutput("midreset_stb_clock", n, 256);

    // Four random frames with occasional random mute toggles.
    curMute = 1'b0;
    for (int i = 0; i < 4 * 256; i++) begin
      if ($urandom_range(0, 199) < 2) curMute = ~curMute;
      applyStimulus(16'($urandom), curMute, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
